// File: rtl/mont_mul_pkg.sv
// Shared constants, FSM state encoding and the Montgomery iteration helper
// used by the mont_mul accelerator.
package mont_mul_pkg;

   localparam int WORDS = 8;
   localparam int OPW   = 256;

   localparam logic [1:0] SEL_B    = 2'd0;
   localparam logic [1:0] SEL_N    = 2'd1;
   localparam logic [1:0] SEL_A    = 2'd2;
   localparam logic [1:0] SEL_RES  = 2'd3;
   localparam logic [1:0] LSU_WORD = 2'b10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LD_A  = 3'd1,
      LD_B  = 3'd2,
      LD_N  = 3'd3,
      CALC  = 3'd4,
      FINAL = 3'd5,
      ST    = 3'd6,
      DONE  = 3'd7
   } state_e;

   // One radix-2 step: add B when the A bit is set, make even with N, halve.
   function automatic logic [OPW+1:0] mont_iter(
      input logic [OPW+1:0] s,
      input logic           a_bit,
      input logic [OPW-1:0] b,
      input logic [OPW-1:0] n
   );
      logic [OPW+1:0] t;
      t = s + (a_bit ? {2'b00, b} : {(OPW+2){1'b0}});
      if (t[0]) begin
         t = t + {2'b00, n};
      end else begin
         t = t;
      end
      return {1'b0, t[OPW+1:1]};
   endfunction

endpackage

// File: rtl/mont_mul_if.sv
// LSU port bundle between the multiplier (master) and the memory side (slave).
interface mont_mul_if;
   import mont_mul_pkg::*;

   logic [1:0]  op_address_sel;
   logic        lsu_ren;
   logic        lsu_wen;
   logic [1:0]  lsu_type;
   logic [31:0] lsu_addr_offset;
   logic        lsu_done;
   logic [31:0] lsu_rdata;
   logic [31:0] lsu_wdata;

   modport master (
      output op_address_sel, lsu_ren, lsu_wen, lsu_type, lsu_addr_offset, lsu_wdata,
      input  lsu_done, lsu_rdata
   );

   modport slave (
      input  op_address_sel, lsu_ren, lsu_wen, lsu_type, lsu_addr_offset, lsu_wdata,
      output lsu_done, lsu_rdata
   );

endinterface

// File: rtl/mont_mul_core.sv
// Datapath: operand registers, 258-bit Montgomery accumulator, bit counter
// and the final conditional subtract that produces the latched result.
module mont_mul_core
   import mont_mul_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   input  logic           ld_a,
   input  logic           ld_b,
   input  logic           ld_n,
   input  logic [2:0]     word_idx,
   input  logic [31:0]    word_data,
   input  logic           step,
   input  logic           fin,
   output logic           calc_last,
   output logic [OPW-1:0] result
);

   logic [OPW-1:0] a_r;
   logic [OPW-1:0] b_r;
   logic [OPW-1:0] n_r;
   logic [OPW-1:0] result_r;
   logic [OPW+1:0] s_r;
   logic [OPW+1:0] s_step_s;
   logic [OPW+1:0] s_fin_s;
   logic [7:0]     bit_cnt_r;
   logic [7:0]     word_base_s;

   // Next accumulator values for a CALC step and for the FINAL reduction.
   always_comb begin
      word_base_s = {word_idx, 5'b00000};
      s_step_s    = mont_iter(s_r, a_r[0], b_r, n_r);
      if (s_r >= {2'b00, n_r}) begin
         s_fin_s = s_r - {2'b00, n_r};
      end else begin
         s_fin_s = s_r;
      end
   end

   // Operand registers; A shifts right during CALC so its current bit is a_r[0].
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r <= {OPW{1'b0}};
         b_r <= {OPW{1'b0}};
         n_r <= {OPW{1'b0}};
      end else begin
         if (ld_a) begin
            a_r[word_base_s +: 32] <= word_data;
         end else if (step) begin
            a_r <= {1'b0, a_r[OPW-1:1]};
         end
         if (ld_b) begin
            b_r[word_base_s +: 32] <= word_data;
         end
         if (ld_n) begin
            n_r[word_base_s +: 32] <= word_data;
         end
      end
   end

   // Accumulator, iteration counter and result latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_r       <= {(OPW+2){1'b0}};
         bit_cnt_r <= 8'd0;
         result_r  <= {OPW{1'b0}};
      end else if (clr) begin
         s_r       <= {(OPW+2){1'b0}};
         bit_cnt_r <= 8'd0;
      end else if (step) begin
         s_r       <= s_step_s;
         bit_cnt_r <= bit_cnt_r + 8'd1;
      end else if (fin) begin
         s_r      <= s_fin_s;
         result_r <= s_fin_s[OPW-1:0];
      end
   end

   assign calc_last = step && (bit_cnt_r == 8'd255);
   assign result    = result_r;

endmodule

// File: rtl/mont_mul.sv
// Montgomery multiplier top: FSM, word counter and LSU sequencing around
// mont_mul_core. Every access holds its request until lsu_done, then idles a cycle.
module mont_mul
   import mont_mul_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   mont_mul_if.master     lsu,
   output logic [OPW-1:0] result,
   output logic           done
);

   state_e         state_r;
   state_e         state_nxt_s;
   logic [2:0]     wcnt_r;
   logic           ren_r;
   logic           wen_r;
   logic           done_r;
   logic [1:0]     sel_r;
   logic [1:0]     type_r;
   logic [31:0]    off_r;
   logic [31:0]    wdata_r;
   logic           ren_nxt_s;
   logic           wen_nxt_s;
   logic [1:0]     sel_nxt_s;
   logic [31:0]    off_nxt_s;
   logic [31:0]    wdata_nxt_s;
   logic           is_load_s;
   logic           acc_done_s;
   logic           last_word_s;
   logic           calc_last_s;
   logic [OPW-1:0] result_s;

   assign acc_done_s  = (ren_r | wen_r) & lsu.lsu_done;
   assign last_word_s = (wcnt_r == 3'd7);

   mont_mul_core u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       ((state_r == IDLE) && start),
      .ld_a      ((state_r == LD_A) && acc_done_s),
      .ld_b      ((state_r == LD_B) && acc_done_s),
      .ld_n      ((state_r == LD_N) && acc_done_s),
      .word_idx  (wcnt_r),
      .word_data (lsu.lsu_rdata),
      .step      (state_r == CALC),
      .fin       (state_r == FINAL),
      .calc_last (calc_last_s),
      .result    (result_s)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE:    state_nxt_s = start ? LD_A : IDLE;
         LD_A:    state_nxt_s = (acc_done_s && last_word_s) ? LD_B : LD_A;
         LD_B:    state_nxt_s = (acc_done_s && last_word_s) ? LD_N : LD_B;
         LD_N:    state_nxt_s = (acc_done_s && last_word_s) ? CALC : LD_N;
         CALC:    state_nxt_s = calc_last_s ? FINAL : CALC;
         FINAL:   state_nxt_s = ST;
         ST:      state_nxt_s = (acc_done_s && last_word_s) ? DONE : ST;
         DONE:    state_nxt_s = start ? DONE : IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Next values of the registered bus outputs; an accepted access forces a one-cycle gap.
   always_comb begin
      is_load_s = (state_r == LD_A) || (state_r == LD_B) || (state_r == LD_N);
      ren_nxt_s = is_load_s && !acc_done_s;
      wen_nxt_s = (state_r == ST) && !acc_done_s;
      off_nxt_s = {27'd0, wcnt_r, 2'b00};
      case (state_r)
         LD_A:    sel_nxt_s = SEL_A;
         LD_B:    sel_nxt_s = SEL_B;
         LD_N:    sel_nxt_s = SEL_N;
         ST:      sel_nxt_s = SEL_RES;
         default: sel_nxt_s = sel_r;
      endcase
      if (state_r == ST) begin
         wdata_nxt_s = result_s[{wcnt_r, 5'b00000} +: 32];
      end else begin
         wdata_nxt_s = 32'd0;
      end
   end

   // Word counter advances once per accepted access and wraps between regions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt_r <= 3'd0;
      end else if (acc_done_s) begin
         wcnt_r <= wcnt_r + 3'd1;
      end else begin
         wcnt_r <= wcnt_r;
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ren_r   <= 1'b0;
         wen_r   <= 1'b0;
         sel_r   <= 2'd0;
         off_r   <= 32'd0;
         wdata_r <= 32'd0;
         type_r  <= 2'b00;
         done_r  <= 1'b0;
      end else begin
         ren_r   <= ren_nxt_s;
         wen_r   <= wen_nxt_s;
         sel_r   <= sel_nxt_s;
         off_r   <= off_nxt_s;
         wdata_r <= wdata_nxt_s;
         type_r  <= LSU_WORD;
         done_r  <= (state_nxt_s == DONE);
      end
   end

   assign lsu.op_address_sel  = sel_r;
   assign lsu.lsu_ren         = ren_r;
   assign lsu.lsu_wen         = wen_r;
   assign lsu.lsu_type        = type_r;
   assign lsu.lsu_addr_offset = off_r;
   assign lsu.lsu_wdata       = wdata_r;
   assign result              = result_s;
   assign done                = done_r;

endmodule

// File: tb/tb_mont_mul.sv
// Directed bench for mont_mul: word memory with configurable latency, bus
// protocol monitor and a modular-arithmetic reference model.
`timescale 1ns/1ps
module tb_mont_mul;
   import mont_mul_pkg::*;

   localparam logic [255:0] NMOD = {4'h7, {61{4'hf}}, 8'hed};

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [255:0] result;
   logic         done;

   mont_mul_if bus ();

   mont_mul dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .lsu    (bus.master),
      .result (result),
      .done   (done)
   );

   always #5 clk = ~clk;

   int           checks = 0;
   int           errors = 0;
   logic [31:0]  mem [0:31];
   int           rd_cnt [0:31];
   int           wr_cnt [0:31];
   int           rd_total;
   int           wr_total;
   int           lat;
   int           cnt;
   logic         pend_q;
   logic [67:0]  req_q;
   logic [255:0] exp_r;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   // Reference: (A*B mod N) times 2^-1 mod N, applied 256 times.
   function automatic logic [255:0] model(input logic [255:0] a, input logic [255:0] b,
                                          input logic [255:0] n);
      logic [511:0] p;
      logic [256:0] x;
      p = ({256'd0, a} * {256'd0, b}) % {256'd0, n};
      x = 257'(p);
      for (int i = 0; i < 256; i++) begin
         x = x[0] ? ((x + {1'b0, n}) >> 1) : (x >> 1);
      end
      return x[255:0];
   endfunction

   function automatic int widx(input logic [1:0] sel, input logic [31:0] off);
      int base;
      case (sel)
         2'd2:    base = 0;
         2'd0:    base = 8;
         2'd1:    base = 16;
         default: base = 24;
      endcase
      return base + int'(off[4:2]);
   endfunction

   // Memory responder plus per-cycle compare against the protocol rules and the model.
   task automatic bus_loop();
      logic        req;
      logic [67:0] cur;
      int          idx;
      forever begin
         @(negedge clk);
         req = bus.lsu_ren | bus.lsu_wen;
         cur = {bus.lsu_ren, bus.lsu_wen, bus.op_address_sel, bus.lsu_addr_offset, bus.lsu_wdata};
         if (!rst_n) begin
            chk("reset_outputs", {result, done, cur, bus.lsu_type}, 256'd0);
            bus.lsu_done = 1'b0;
            cnt = 0;
            pend_q = 1'b0;
         end else begin
            if (done) chk("result_in_done", result, exp_r);
            if (bus.lsu_done) begin
               chk("gap_after_done", {255'd0, req}, 256'd0);
               bus.lsu_done = 1'b0;
               cnt = 0;
               pend_q = 1'b0;
            end else if (req) begin
               chk("ren_wen_exclusive", {255'd0, bus.lsu_ren & bus.lsu_wen}, 256'd0);
               chk("lsu_type", {254'd0, bus.lsu_type}, {254'd0, LSU_WORD});
               chk("offset_range", {224'd0, bus.lsu_addr_offset & 32'hffff_ffe3}, 256'd0);
               if (pend_q) chk("request_stable", {188'd0, cur}, {188'd0, req_q});
               pend_q = 1'b1;
               req_q = cur;
               if (cnt >= lat) begin
                  idx = widx(bus.op_address_sel, bus.lsu_addr_offset);
                  if (bus.lsu_ren) begin
                     bus.lsu_rdata = mem[idx];
                     rd_cnt[idx]++;
                     rd_total++;
                  end else begin
                     mem[idx] = bus.lsu_wdata;
                     wr_cnt[idx]++;
                     wr_total++;
                  end
                  bus.lsu_done = 1'b1;
               end else begin
                  cnt++;
               end
            end else begin
               cnt = 0;
               pend_q = 1'b0;
            end
         end
      end
   endtask

   task automatic setup(input logic [255:0] a, input logic [255:0] b, input int l);
      for (int i = 0; i < 8; i++) begin
         mem[i]      = a[32*i +: 32];
         mem[8 + i]  = b[32*i +: 32];
         mem[16 + i] = NMOD[32*i +: 32];
         mem[24 + i] = 32'hdead_beef;
      end
      for (int i = 0; i < 32; i++) begin
         rd_cnt[i] = 0;
         wr_cnt[i] = 0;
      end
      rd_total = 0;
      wr_total = 0;
      lat = l;
      exp_r = model(a, b, NMOD);
   endtask

   task automatic run(input string nm, input logic [255:0] a, input logic [255:0] b,
                      input int l, input logic [255:0] lit);
      int  k;
      int  snap;
      logic ok;
      setup(a, b, l);
      chk({nm, "_model"}, exp_r, lit);
      @(posedge clk); #1 start = 1'b1;
      k = 0;
      while (!done && k < 5000) begin
         @(posedge clk); #1;
         k++;
      end
      chk({nm, "_done_timeout"}, {255'd0, done}, 256'd1);
      chk({nm, "_result"}, result, lit);
      snap = rd_total + wr_total;
      repeat (6) @(posedge clk);
      #1;
      chk({nm, "_done_held"}, {255'd0, done}, 256'd1);
      chk({nm, "_no_access_in_done"}, 256'(rd_total + wr_total), 256'(snap));
      for (int i = 0; i < 8; i++) chk({nm, "_res_word"}, {224'd0, mem[24 + i]}, {224'd0, lit[32*i +: 32]});
      ok = 1'b1;
      for (int i = 0; i < 32; i++) begin
         if (rd_cnt[i] != ((i < 24) ? 1 : 0) || wr_cnt[i] != ((i < 24) ? 0 : 1)) ok = 1'b0;
      end
      chk({nm, "_single_access"}, {255'd0, ok}, 256'd1);
      start = 1'b0;
      k = 0;
      while (done && k < 10) begin
         @(posedge clk); #1;
         k++;
      end
      chk({nm, "_idle_after_start_low"}, {255'd0, done}, 256'd0);
   endtask

   initial begin
      int k;
      bus.lsu_done  = 1'b0;
      bus.lsu_rdata = 32'd0;
      lat = 0;
      cnt = 0;
      pend_q = 1'b0;
      req_q = 68'd0;
      exp_r = 256'd0;
      fork
         bus_loop();
      join_none
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      chk("pin_model_nm1", model(NMOD - 256'd1, 256'd38, NMOD), {4'h7, {61{4'hf}}, 8'hec});
      chk("pin_model_one", model(256'd38, 256'd5, NMOD), 256'd5);

      run("a38_b5",    256'd38, 256'd5,   0, 256'd5);
      run("a38_b38",   256'd38, 256'd38,  0, 256'd38);
      run("a0_b123",   256'd0,  256'd123, 0, 256'd0);
      run("nm1_b38",   NMOD - 256'd1, 256'd38, 0, {4'h7, {61{4'hf}}, 8'hec});
      run("slow_lsu",  256'd38, 256'd5,   3, 256'd5);

      // Abort mid-CALC, then a clean rerun.
      setup(256'd38, 256'd5, 0);
      @(posedge clk); #1 start = 1'b1;
      k = 0;
      while (rd_total < 24 && k < 2000) begin
         @(posedge clk); #1;
         k++;
      end
      chk("abort_reads_complete", 256'(rd_total), 256'd24);
      repeat (20) @(posedge clk);
      #1 rst_n = 1'b0;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (400) @(posedge clk);
      #1;
      chk("abort_no_writes", 256'(wr_total), 256'd0);
      chk("abort_not_done", {255'd0, done}, 256'd0);

      run("a38_b7",    256'd38, 256'd7, 0, 256'd7);
      run("a38_b7_2",  256'd38, 256'd7, 0, 256'd7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
